tx_pkt_buf: RTL and testbench
=============================

# tx_pkt_buf

Packet staging buffer that feeds `dot11_tx` from the MAC side. It accepts one PPDU's worth of 64-bit words on a valid/ready stream, writes them into an internal 4096×64 RAM, and pulses `phy_tx_start`. It then serves `dot11_tx` reads on `bram_addr`/`bram_din` with one-cycle latency and releases the buffer on `phy_tx_done`.

## Interface
Parameters:
- `ADDR_W`, 12: RAM address width (depth 2^ADDR_W words).
- `START_CYC`, 5: cycles `phy_tx_start` is held high (≥1).
- `WDOG_CYC`, 1000000: watchdog limit in cycles. Used only with the watchdog macro.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `s_data` in 64: packet word.
- `s_valid` in 1: word valid.
- `s_last` in 1: last word of packet; qualified by `s_valid`.
- `s_ready` out 1: buffer accepts words.
- `bram_addr` in ADDR_W: read address from `dot11_tx`.
- `bram_din` out 64: read data to `dot11_tx`.
- `phy_tx_start` out 1: start request to `dot11_tx`.
- `phy_tx_started` in 1: informational, counted only.
- `phy_tx_done` in 1: end of transmission.
- `busy` out 1: high in every state except IDLE/LOAD.
- `pkt_words` out ADDR_W+1: word count of the last accepted packet.
- `tx_count` out 16: completed transmissions; wraps at 2^16.
- `err_overflow` out 1: sticky packet-too-long flag.
- `err_timeout` out 1: sticky watchdog flag. Constant 0 without the macro.

## Operation
- FSM states: IDLE, LOAD, START, WAIT_DONE.
- IDLE: `s_ready`=1, write pointer = 0.
  - On the first handshake (`s_valid & s_ready`), write the word to address 0 and go to LOAD.
  - If that word also has `s_last`, go directly to START.
- LOAD: `s_ready`=1. Each handshake writes `s_data` at the pointer, then increments the pointer.
  - On a handshake with `s_last`: set `pkt_words` = pointer+1 and go to START.
- Overflow: when the pointer reaches 2^ADDR_W, words are accepted and discarded, and `err_overflow` is set.
  - On `s_last`, return to IDLE without transmitting. `pkt_words` holds 2^ADDR_W.
- START: `s_ready`=0, `phy_tx_start`=1 for exactly START_CYC cycles, then go to WAIT_DONE.
- WAIT_DONE: `s_ready`=0. A cycle with `phy_tx_done`=1 increments `tx_count` and returns to IDLE.
- `phy_tx_done` is ignored outside WAIT_DONE.
- Read port is active in every state: `bram_din` <= RAM[`bram_addr`] on each rising edge.
- Same-cycle write and read of one address returns the old data (read-first).
- Sticky errors clear only on reset.
- Reset mid-operation:
  - The FSM returns to IDLE and every output takes its reset value.
  - RAM contents are not cleared.

## Timing
- Reset values: `s_ready`=0 while `rstn`=0, then 1 in the first cycle after release. All other outputs are 0, including `bram_din`.
- Write latency: a word accepted in cycle n is readable via `bram_addr` from cycle n+1. Its data appears on `bram_din` one cycle after the address.
- `phy_tx_start` rises in the cycle after the last-word handshake and is high for START_CYC cycles.
- Return path: `phy_tx_done` sampled high in cycle n → `busy`=0 and `s_ready`=1 in cycle n+1.
- Throughput: one word per cycle in LOAD.
- Overhead between packets: START_CYC cycles plus the `dot11_tx` run time, plus 1 cycle.

## Configuration
- Macro `TX_PKT_BUF_WATCHDOG_EN`.
- Defined:
  - A counter runs in WAIT_DONE.
  - If WDOG_CYC cycles pass without `phy_tx_done`, set `err_timeout` and go to IDLE; `tx_count` is not incremented.
  - `phy_tx_done` in the final cycle takes priority and counts as a normal completion.
- Undefined: no counter, `err_timeout` is tied to 0, and WAIT_DONE waits indefinitely.

## Test plan
- 13 words 0x1..0xD, last on word 13:
  - `pkt_words`=13; `phy_tx_start` high for 5 cycles starting the cycle after the handshake.
  - Reading `bram_addr`=4 returns 0x5 one cycle later.
- Single-word packet with `s_last` in IDLE → START directly; `pkt_words`=1.
- `s_valid` held during START/WAIT_DONE → `s_ready`=0 and no writes. `phy_tx_done` then gives `tx_count`=1, and `s_ready`=1 the next cycle.
- 4097 words with ADDR_W=12 → `err_overflow`=1, no `phy_tx_start`, FSM back in IDLE.
- `rstn` low in WAIT_DONE:
  - All outputs go to 0 asynchronously.
  - After release, previously written RAM data is still readable.
- With `TX_PKT_BUF_WATCHDOG_EN` and WDOG_CYC=20, no `phy_tx_done` → `err_timeout`=1 after 20 WAIT_DONE cycles, `tx_count` unchanged.

Source files
------------

// File: rtl/tx_pkt_buf.sv
// Stages one PPDU of 64-bit words into a 2^ADDR_W x 64 RAM, then requests transmission from dot11_tx.
// Latency: write-to-readable 1 cycle, read data 1 cycle after bram_addr, phy_tx_start the cycle after the last word.
// Backpressure: s_ready is low from the last-word handshake until phy_tx_done; optional watchdog via TX_PKT_BUF_WATCHDOG_EN.
module tx_pkt_buf #(
    parameter int ADDR_W    = 12,
    parameter int START_CYC = 5,
    parameter int WDOG_CYC  = 1000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [63:0]       s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] bram_addr,
    output logic [63:0]       bram_din,
    output logic              phy_tx_start,
    input  logic              phy_tx_started,
    input  logic              phy_tx_done,
    output logic              busy,
    output logic [ADDR_W:0]   pkt_words,
    output logic [15:0]       tx_count,
    output logic              err_overflow,
    output logic              err_timeout
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SC_W  = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PKT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [63:0]      mem [0:DEPTH-1];
    logic [ADDR_W:0]  wr_ptr_q;
    logic [SC_W-1:0]  start_cnt_q;
    logic             ready_en_q;
    logic [15:0]      started_cnt_q;

    logic hs;
    logic ptr_full;
    logic wr_en;
    logic start_last;
    logic wdog_expire;

    // Pointer bit ADDR_W set means the RAM is full and further words are dropped.
    assign hs         = s_valid & s_ready;
    assign ptr_full   = wr_ptr_q[ADDR_W];
    assign wr_en      = hs & ~ptr_full;
    assign start_last = (start_cnt_q == SC_LAST);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; phy_tx_done wins over a watchdog expiry in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = s_last ? ST_START : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (hs && s_last) begin
                    state_d = ptr_full ? ST_IDLE : ST_START;
                end
            end
            ST_START: begin
                if (start_last) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (phy_tx_done || wdog_expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; ready_en_q keeps s_ready low until the first edge after reset release
    always_comb begin
        s_ready      = ready_en_q & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
        phy_tx_start = (state_q == ST_START);
        busy         = (state_q == ST_START) | (state_q == ST_WAIT);
    end

    // Ready enable comes up one edge after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Write pointer: advances per stored word, parks at full, rewinds to 0 at end of packet
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
        end else if (hs) begin
            if (s_last) begin
                wr_ptr_q <= '0;
            end else if (!ptr_full) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
        end
    end

    // Packet length capture; an overflowed packet reports the full RAM depth
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_words <= '0;
        end else if (hs && s_last) begin
            pkt_words <= ptr_full ? PKT_MAX : (wr_ptr_q + PTR_ONE);
        end
    end

    // Sticky overflow: set whenever a word has to be dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_overflow <= 1'b0;
        end else if (hs && ptr_full) begin
            err_overflow <= 1'b1;
        end
    end

    // START dwell counter, held at zero outside START
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_cnt_q <= '0;
        end else if (state_q == ST_START) begin
            start_cnt_q <= start_cnt_q + 1'b1;
        end else begin
            start_cnt_q <= '0;
        end
    end

    // Completed transmission counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_count <= '0;
        end else if ((state_q == ST_WAIT) && phy_tx_done) begin
            tx_count <= tx_count + 16'd1;
        end
    end

    // phy_tx_started events are tallied for debug visibility only
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            started_cnt_q <= '0;
        end else if (phy_tx_started) begin
            started_cnt_q <= started_cnt_q + 16'd1;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= s_data;
        end
    end

    // RAM read port, live in every state; same-address write returns the old word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bram_din <= '0;
        end else begin
            bram_din <= mem[bram_addr];
        end
    end

`ifdef TX_PKT_BUF_WATCHDOG_EN
    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

    logic [WD_W-1:0] wd_cnt_q;

    assign wdog_expire = (state_q == ST_WAIT) && (wd_cnt_q == WD_LAST);

    // Watchdog counts WAIT_DONE cycles, cleared whenever we are elsewhere
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end else begin
            wd_cnt_q <= '0;
        end
    end

    // Sticky timeout only when the final watchdog cycle has no phy_tx_done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_timeout <= 1'b0;
        end else if (wdog_expire && !phy_tx_done) begin
            err_timeout <= 1'b1;
        end
    end
`else
    logic unused_wdog;

    assign wdog_expire = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_wdog = (WDOG_CYC > 0);
`endif

    logic unused_started;
    assign unused_started = ^started_cnt_q;

endmodule

// File: tb/tb_tx_pkt_buf.sv
// Directed bench for tx_pkt_buf: load/start/done flow, read port, overflow, reset, watchdog.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Each scenario task checks its own results and bumps the shared counters.
module tb_tx_pkt_buf;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rstn;
    logic [63:0]       s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [ADDR_W-1:0] bram_addr;
    logic [63:0]       bram_din;
    logic              phy_tx_start;
    logic              phy_tx_started;
    logic              phy_tx_done;
    logic              busy;
    logic [ADDR_W:0]   pkt_words;
    logic [15:0]       tx_count;
    logic              err_overflow;
    logic              err_timeout;

    int vec_cnt;
    int err_cnt;

    tx_pkt_buf #(
        .ADDR_W    (ADDR_W),
        .START_CYC (5),
        .WDOG_CYC  (20)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .bram_addr      (bram_addr),
        .bram_din       (bram_din),
        .phy_tx_start   (phy_tx_start),
        .phy_tx_started (phy_tx_started),
        .phy_tx_done    (phy_tx_done),
        .busy           (busy),
        .pkt_words      (pkt_words),
        .tx_count       (tx_count),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        bram_addr = '0; phy_tx_started = 1'b0; phy_tx_done = 1'b0;
        #12;
        vec_cnt++; if (s_ready !== 1'b0)      begin err_cnt++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        vec_cnt++; if (busy !== 1'b0)         begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        vec_cnt++; if (phy_tx_start !== 1'b0) begin err_cnt++; $display("FAIL rst_start: got %b want 0", phy_tx_start); end
        vec_cnt++; if (pkt_words !== '0)      begin err_cnt++; $display("FAIL rst_pkt_words: got %0d want 0", pkt_words); end
        vec_cnt++; if (tx_count !== 16'd0)    begin err_cnt++; $display("FAIL rst_tx_count: got %0d want 0", tx_count); end
        vec_cnt++; if (err_overflow !== 1'b0) begin err_cnt++; $display("FAIL rst_err_ovf: got %b want 0", err_overflow); end
        vec_cnt++; if (err_timeout !== 1'b0)  begin err_cnt++; $display("FAIL rst_err_to: got %b want 0", err_timeout); end
        vec_cnt++; if (bram_din !== 64'd0)    begin err_cnt++; $display("FAIL rst_bram_din: got %h want 0", bram_din); end
        @(posedge clk);
        #3 rstn = 1'b1;
        tick;
        vec_cnt++; if (s_ready !== 1'b1)      begin err_cnt++; $display("FAIL rst_release_ready: got %b want 1", s_ready); end
    endtask

    // 13-word packet, then s_valid held high through START/WAIT_DONE
    task automatic test_basic_load;
        for (int i = 1; i <= 13; i++) begin
            s_data = 64'(i); s_valid = 1'b1; s_last = (i == 13);
            vec_cnt++; if (s_ready !== 1'b1) begin err_cnt++; $display("FAIL load_ready word %0d: got %b want 1", i, s_ready); end
            tick;
        end
        s_data = 64'hDEAD_BEEF; s_last = 1'b0;
        vec_cnt++; if (pkt_words !== 13'd13) begin err_cnt++; $display("FAIL load_pkt_words: got %0d want 13", pkt_words); end
        for (int k = 0; k < 5; k++) begin
            vec_cnt++; if (phy_tx_start !== 1'b1) begin err_cnt++; $display("FAIL start_high cyc %0d: got %b want 1", k, phy_tx_start); end
            vec_cnt++; if (s_ready !== 1'b0)      begin err_cnt++; $display("FAIL start_ready cyc %0d: got %b want 0", k, s_ready); end
            tick;
        end
        vec_cnt++; if (phy_tx_start !== 1'b0) begin err_cnt++; $display("FAIL start_width: got %b want 0 after 5 cycles", phy_tx_start); end
        vec_cnt++; if (busy !== 1'b1)         begin err_cnt++; $display("FAIL wait_busy: got %b want 1", busy); end
        vec_cnt++; if (s_ready !== 1'b0)      begin err_cnt++; $display("FAIL wait_ready: got %b want 0", s_ready); end
        bram_addr = 12'd4; tick;
        vec_cnt++; if (bram_din !== 64'h5) begin err_cnt++; $display("FAIL read_addr4: got %h want 5", bram_din); end
        bram_addr = 12'd0; tick;
        vec_cnt++; if (bram_din !== 64'h1) begin err_cnt++; $display("FAIL read_addr0: got %h want 1", bram_din); end
        bram_addr = 12'd12; tick;
        vec_cnt++; if (bram_din !== 64'hD) begin err_cnt++; $display("FAIL read_addr12: got %h want d", bram_din); end
        bram_addr = 12'd13; tick;
        vec_cnt++; if (bram_din === 64'hDEAD_BEEF) begin err_cnt++; $display("FAIL hold_no_write: got %h want not deadbeef", bram_din); end
        s_valid = 1'b0; phy_tx_done = 1'b1; tick; phy_tx_done = 1'b0;
        vec_cnt++; if (busy !== 1'b0)      begin err_cnt++; $display("FAIL done_busy: got %b want 0", busy); end
        vec_cnt++; if (s_ready !== 1'b1)   begin err_cnt++; $display("FAIL done_ready: got %b want 1", s_ready); end
        vec_cnt++; if (tx_count !== 16'd1) begin err_cnt++; $display("FAIL done_tx_count: got %0d want 1", tx_count); end
    endtask

    // Single-word packet straight from IDLE, read-first collision, done ignored outside WAIT_DONE
    task automatic test_single_word;
        phy_tx_done = 1'b1; tick; phy_tx_done = 1'b0;
        vec_cnt++; if (tx_count !== 16'd1) begin err_cnt++; $display("FAIL idle_done_ignored: got %0d want 1", tx_count); end
        bram_addr = 12'd0; s_data = 64'hABC; s_valid = 1'b1; s_last = 1'b1;
        tick;
        s_valid = 1'b0; s_last = 1'b0;
        vec_cnt++; if (bram_din !== 64'h1)     begin err_cnt++; $display("FAIL read_first: got %h want 1", bram_din); end
        vec_cnt++; if (phy_tx_start !== 1'b1)  begin err_cnt++; $display("FAIL single_start: got %b want 1", phy_tx_start); end
        vec_cnt++; if (pkt_words !== 13'd1)    begin err_cnt++; $display("FAIL single_pkt_words: got %0d want 1", pkt_words); end
        tick;
        vec_cnt++; if (bram_din !== 64'hABC)   begin err_cnt++; $display("FAIL write_visible: got %h want abc", bram_din); end
        phy_tx_done = 1'b1; tick; phy_tx_done = 1'b0;
        vec_cnt++; if (phy_tx_start !== 1'b1)  begin err_cnt++; $display("FAIL start_done_ignored: got %b want 1", phy_tx_start); end
        repeat (3) tick;
        vec_cnt++; if (busy !== 1'b1 || phy_tx_start !== 1'b0) begin err_cnt++; $display("FAIL single_wait: got busy %b start %b want 1 0", busy, phy_tx_start); end
        vec_cnt++; if (tx_count !== 16'd1)     begin err_cnt++; $display("FAIL single_pre_done: got %0d want 1", tx_count); end
        phy_tx_done = 1'b1; tick; phy_tx_done = 1'b0;
        vec_cnt++; if (tx_count !== 16'd2)     begin err_cnt++; $display("FAIL single_tx_count: got %0d want 2", tx_count); end
    endtask

    // 4097-word packet: last word dropped, no transmission
    task automatic test_overflow;
        logic seen_start;
        seen_start = 1'b0;
        for (int i = 0; i <= 4096; i++) begin
            s_data = 64'h100 + 64'(i); s_valid = 1'b1; s_last = (i == 4096);
            tick;
            if (phy_tx_start) seen_start = 1'b1;
            if (i == 4095) begin
                vec_cnt++; if (err_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
                vec_cnt++; if (s_ready !== 1'b1)      begin err_cnt++; $display("FAIL ovf_ready_full: got %b want 1", s_ready); end
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) begin
            tick;
            if (phy_tx_start) seen_start = 1'b1;
        end
        vec_cnt++; if (err_overflow !== 1'b1)    begin err_cnt++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
        vec_cnt++; if (seen_start !== 1'b0)      begin err_cnt++; $display("FAIL ovf_no_start: got %b want 0", seen_start); end
        vec_cnt++; if (busy !== 1'b0 || s_ready !== 1'b1) begin err_cnt++; $display("FAIL ovf_idle: got busy %b ready %b want 0 1", busy, s_ready); end
        vec_cnt++; if (pkt_words !== 13'd4096)   begin err_cnt++; $display("FAIL ovf_pkt_words: got %0d want 4096", pkt_words); end
        vec_cnt++; if (tx_count !== 16'd2)       begin err_cnt++; $display("FAIL ovf_tx_count: got %0d want 2", tx_count); end
        bram_addr = 12'hFFF; tick;
        vec_cnt++; if (bram_din !== 64'h10FF)    begin err_cnt++; $display("FAIL ovf_read_last: got %h want 10ff", bram_din); end
        bram_addr = 12'h000; tick;
        vec_cnt++; if (bram_din !== 64'h100)     begin err_cnt++; $display("FAIL ovf_read_first: got %h want 100", bram_din); end
    endtask

    // Reset asserted in WAIT_DONE; RAM must survive
    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            s_data = 64'h77 + 64'(i) * 64'h11; s_valid = 1'b1; s_last = (i == 2);
            tick;
        end
        s_valid = 1'b0; s_last = 1'b0;
        repeat (5) tick;
        vec_cnt++; if (busy !== 1'b1)       begin err_cnt++; $display("FAIL mid_busy: got %b want 1", busy); end
        bram_addr = 12'd1; tick;
        vec_cnt++; if (bram_din !== 64'h88) begin err_cnt++; $display("FAIL mid_read: got %h want 88", bram_din); end
        #2 rstn = 1'b0;
        #1;
        vec_cnt++; if (busy !== 1'b0)         begin err_cnt++; $display("FAIL arst_busy: got %b want 0", busy); end
        vec_cnt++; if (s_ready !== 1'b0)      begin err_cnt++; $display("FAIL arst_ready: got %b want 0", s_ready); end
        vec_cnt++; if (tx_count !== 16'd0)    begin err_cnt++; $display("FAIL arst_tx_count: got %0d want 0", tx_count); end
        vec_cnt++; if (pkt_words !== '0)      begin err_cnt++; $display("FAIL arst_pkt_words: got %0d want 0", pkt_words); end
        vec_cnt++; if (err_overflow !== 1'b0) begin err_cnt++; $display("FAIL arst_err_ovf: got %b want 0", err_overflow); end
        vec_cnt++; if (bram_din !== 64'd0)    begin err_cnt++; $display("FAIL arst_bram_din: got %h want 0", bram_din); end
        #2 rstn = 1'b1;
        tick;
        vec_cnt++; if (s_ready !== 1'b1)      begin err_cnt++; $display("FAIL post_rst_ready: got %b want 1", s_ready); end
        vec_cnt++; if (bram_din !== 64'h88)   begin err_cnt++; $display("FAIL ram_retained: got %h want 88", bram_din); end
    endtask

    // WAIT_DONE without phy_tx_done
    task automatic test_watchdog;
        s_data = 64'h5A; s_valid = 1'b1; s_last = 1'b1;
        tick;
        s_valid = 1'b0; s_last = 1'b0;
        repeat (24) tick;
        vec_cnt++; if (busy !== 1'b1)        begin err_cnt++; $display("FAIL wd_busy_20: got %b want 1", busy); end
        vec_cnt++; if (err_timeout !== 1'b0) begin err_cnt++; $display("FAIL wd_early: got %b want 0", err_timeout); end
        tick;
`ifdef TX_PKT_BUF_WATCHDOG_EN
        vec_cnt++; if (err_timeout !== 1'b1) begin err_cnt++; $display("FAIL wd_flag: got %b want 1", err_timeout); end
        vec_cnt++; if (busy !== 1'b0 || s_ready !== 1'b1) begin err_cnt++; $display("FAIL wd_idle: got busy %b ready %b want 0 1", busy, s_ready); end
        vec_cnt++; if (tx_count !== 16'd0)   begin err_cnt++; $display("FAIL wd_tx_count: got %0d want 0", tx_count); end
`else
        repeat (10) tick;
        vec_cnt++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin err_cnt++; $display("FAIL nowd_wait: got busy %b to %b want 1 0", busy, err_timeout); end
        phy_tx_done = 1'b1; tick; phy_tx_done = 1'b0;
        vec_cnt++; if (tx_count !== 16'd1)   begin err_cnt++; $display("FAIL nowd_done: got %0d want 1", tx_count); end
`endif
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_basic_load();
        test_single_word();
        test_overflow();
        test_reset_mid();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
